vid_tpg_packet_source: RTL and testbench
========================================

VID_TPG_PACKET_SOURCE -- requirements
Module: vid_tpg_packet_source

Interface
REQ-001 SHALL have parameter BPS, default 8, bits per symbol (4..16).
REQ-002 SHALL have parameter PLANES, default 3, colour planes per beat (1..4).
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port enable, input, 1, start/continue frame generation.
REQ-006 SHALL have port cfg_width, input, 16, active pixels per line.
REQ-007 SHALL have port cfg_height, input, 16, active lines.
REQ-008 SHALL have port cfg_interlace, input, 4, interlace nibble.
REQ-009 SHALL have port cfg_pattern, input, 2, pattern select.
REQ-010 SHALL have port dout_data, output, PLANES*BPS, Avalon-ST video data; symbol 0 in LSBs.
REQ-011 SHALL have ports dout_valid, dout_sop and dout_eop, output, 1 each, Avalon-ST qualifiers.
REQ-012 SHALL have port dout_ready, input, 1, downstream ready (ready latency 0).
REQ-013 SHALL have port busy, output, 1, high outside IDLE.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse after the final video eop beat transfers.

Function
REQ-015 SHALL transfer a beat on any cycle with dout_valid & dout_ready; while valid & ~ready, data, sop and eop SHALL stay stable.
REQ-016 SHALL implement states IDLE, CTRL_HDR, CTRL_BODY, VID_HDR, VID_DATA.
REQ-017 IDLE: when enable=1, SHALL latch cfg_* and enter CTRL_HDR; dout_valid SHALL rise the next cycle.
REQ-018 SHALL clamp a latched width or height of 0 to 1.
REQ-019 CTRL_HDR SHALL emit one beat: sop=1, symbol0[3:0]=15, all other bits 0.
REQ-020 CTRL_BODY SHALL emit ceil(9/PLANES) beats carrying nibble sequence W[15:12],W[11:8],W[7:4],W[3:0],H[15:12],H[11:8],H[7:4],H[3:0],interlace.
REQ-021 Symbol s of body beat k SHALL carry nibble k*PLANES+s in bits [3:0]; upper bits and symbols beyond nibble 8 SHALL be 0; eop=1 on the last body beat.
REQ-022 VID_HDR SHALL emit one beat: sop=1, symbol0[3:0]=0, all other bits 0.
REQ-023 VID_DATA SHALL emit W*H beats in raster order (x fastest); eop=1 only at x=W-1, y=H-1.
REQ-024 All planes of a pixel beat SHALL carry the same value: pattern 0 all-ones; 1 x[BPS-1:0]; 2 y[BPS-1:0]; 3 all-ones if (x^y)[3], else 0.
REQ-025 x SHALL wrap to 0 and y SHALL increment on transfer at x=W-1; both counters SHALL reset to 0 on entering VID_DATA.
REQ-026 After the final eop transfer, SHALL pulse frame_done and return to IDLE; IDLE SHALL last exactly one cycle when enable is still 1.
REQ-027 Deasserting enable mid-frame SHALL NOT truncate the frame; cfg_* changes mid-frame SHALL be ignored.
REQ-028 Combined with a non-stalling sink, total beats per frame SHALL be 2+ceil(9/PLANES)+W*H.

Reset
REQ-029 On rst, state SHALL be IDLE, x=y=0, and dout_valid, dout_sop, dout_eop, busy and frame_done SHALL be 0, dout_data 0, immediately and asynchronously.
REQ-030 rst asserted mid-frame SHALL abandon the frame; after release, the next frame SHALL start with a control packet.

Structure
REQ-031 A shared package SHALL hold the state enum, packet-type constants (VIDEO=0, CONTROL=15) and the nibble count (9).
REQ-032 The x/y raster counter with wrap and last-pixel flag SHALL be sub-module vid_tpg_raster_counter.

Verification
REQ-033 PLANES=3, W=4, H=2, pattern 1, ready=1 -> beats: ctrl 0x00F sop; 3 body beats of nibbles 0,0,0 / 4,0,0 / 0,2,0(eop) per nibble order; video hdr; 8 pixels 0,1,2,3,0,1,2,3, eop on 8th; frame_done one cycle later.
REQ-034 PLANES=1, W=1, H=1 -> 9 body beats, 1 pixel beat with sop=0 and eop=1; 12 beats total.
REQ-035 Toggle dout_ready 1/0 every cycle during VID_DATA -> identical beat sequence to REQ-033; data stable across stalls.
REQ-036 cfg_width=0, cfg_height=0 -> control body encodes 0, exactly 1 pixel beat is emitted.
REQ-037 rst pulsed during pixel 3 -> dout_valid=0 at once; after release with enable=1, next beat is ctrl header with sop=1.
REQ-038 enable held 1, two frames -> exactly one non-valid cycle between the first frame's eop and the second frame's ctrl sop.

Source files
------------

// File: rtl/vid_tpg_packet_source_pkg.sv
// Shared types and constants for the test-pattern packet source: FSM states,
// Avalon-ST video packet type codes and the control-packet nibble layout.
package vid_tpg_packet_source_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CTRL_HDR,
      CTRL_BODY,
      VID_HDR,
      VID_DATA
   } tpg_state_t;

   localparam logic [3:0] PKT_VIDEO    = 4'd0;
   localparam logic [3:0] PKT_CONTROL  = 4'd15;
   localparam int         NIBBLE_COUNT = 9;

   // Control body nibble order: width MSN first, then height MSN first, then interlace.
   function automatic logic [3:0] ctrl_nibble(input int idx,
                                              input logic [15:0] w,
                                              input logic [15:0] h,
                                              input logic [3:0] il);
      case (idx)
         0:       return w[15:12];
         1:       return w[11:8];
         2:       return w[7:4];
         3:       return w[3:0];
         4:       return h[15:12];
         5:       return h[11:8];
         6:       return h[7:4];
         7:       return h[3:0];
         8:       return il;
         default: return 4'h0;
      endcase
   endfunction

endpackage

// File: rtl/vid_tpg_packet_source_if.sv
// Avalon-ST video source bus carrying one beat of PLANES symbols per transfer.
interface vid_tpg_packet_source_if #(
   parameter int BPS    = 8,
   parameter int PLANES = 3
);
   // A beat transfers on every clock edge where dout_valid & dout_ready (ready latency 0);
   // while dout_valid is high and dout_ready low, data/sop/eop are held unchanged.
   logic [PLANES*BPS-1:0] dout_data;
   logic                  dout_valid;
   logic                  dout_sop;
   logic                  dout_eop;
   logic                  dout_ready;

   modport master (
      output dout_data,
      output dout_valid,
      output dout_sop,
      output dout_eop,
      input  dout_ready
   );

   modport slave (
      input  dout_data,
      input  dout_valid,
      input  dout_sop,
      input  dout_eop,
      output dout_ready
   );
endinterface

// File: rtl/vid_tpg_raster_counter.sv
// Pixel raster position: x runs fastest, wraps at width-1 and bumps y.
module vid_tpg_raster_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        advance,
   input  logic [15:0] width,
   input  logic [15:0] height,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic        last
);

   logic x_end;
   logic y_end;

   // width and height arrive already clamped to at least 1.
   assign x_end = (x == width - 16'd1);
   assign y_end = (y == height - 16'd1);
   assign last  = x_end & y_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (x_end) begin
            x <= '0;
            y <= y + 16'd1;
         end else begin
            x <= x + 16'd1;
         end
      end
   end

endmodule

// File: rtl/vid_tpg_packet_source.sv
// Test-pattern generator: per frame emits a control packet (size/interlace)
// followed by a video packet of W*H pattern pixels on an Avalon-ST source.
module vid_tpg_packet_source
   import vid_tpg_packet_source_pkg::*;
#(
   parameter int BPS    = 8,
   parameter int PLANES = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [15:0]                   cfg_width,
   input  logic [15:0]                   cfg_height,
   input  logic [3:0]                    cfg_interlace,
   input  logic [1:0]                    cfg_pattern,
   vid_tpg_packet_source_if.master       dout,
   output logic                          busy,
   output logic                          frame_done,
   output tpg_state_t                    dbg_state
);

   localparam int         DW         = PLANES * BPS;
   localparam int         BODY_BEATS = (NIBBLE_COUNT + PLANES - 1) / PLANES;
   localparam logic [3:0] LAST_BODY  = 4'(BODY_BEATS - 1);

   tpg_state_t     state;
   tpg_state_t     state_nxt;

   logic [15:0]    w_q;
   logic [15:0]    h_q;
   logic [3:0]     il_q;
   logic [1:0]     pat_q;
   logic [15:0]    w_eff;
   logic [15:0]    h_eff;

   logic [3:0]     body_k;
   logic [DW-1:0]  body_data;

   logic [15:0]    px_x;
   logic [15:0]    px_y;
   logic           px_last;
   logic [BPS-1:0] pix_val;
   logic           unused_bits;

   logic           xfer;
   logic           valid_c;
   logic           sop_c;
   logic           eop_c;
   logic [DW-1:0]  data_c;

   assign xfer = dout.dout_valid & dout.dout_ready;

   // Raw size goes into the control packet; the raster uses the clamped size.
   assign w_eff = (w_q == 16'd0) ? 16'd1 : w_q;
   assign h_eff = (h_q == 16'd0) ? 16'd1 : h_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q   <= '0;
         h_q   <= '0;
         il_q  <= '0;
         pat_q <= '0;
      end else if (state == IDLE && enable) begin
         w_q   <= cfg_width;
         h_q   <= cfg_height;
         il_q  <= cfg_interlace;
         pat_q <= cfg_pattern;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         body_k <= '0;
      end else if (state != CTRL_BODY) begin
         body_k <= '0;
      end else if (xfer) begin
         body_k <= body_k + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= (state == VID_DATA) && xfer && px_last;
      end
   end

   vid_tpg_raster_counter u_raster (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != VID_DATA),
      .advance ((state == VID_DATA) && xfer),
      .width   (w_eff),
      .height  (h_eff),
      .x       (px_x),
      .y       (px_y),
      .last    (px_last)
   );

   always_comb begin
      body_data = '0;
      for (int s = 0; s < PLANES; s++) begin
         if (int'(body_k) * PLANES + s < NIBBLE_COUNT) begin
            body_data[s*BPS +: 4] = ctrl_nibble(int'(body_k) * PLANES + s, w_q, h_q, il_q);
         end
      end
   end

   always_comb begin
      pix_val = '0;
      case (pat_q)
         2'd0:    pix_val = '1;
         2'd1:    pix_val = px_x[BPS-1:0];
         2'd2:    pix_val = px_y[BPS-1:0];
         default: pix_val = (px_x[3] ^ px_y[3]) ? '1 : '0;
      endcase
   end

   assign unused_bits = ^{px_x, px_y};

   // Outputs are pure functions of registered state, so they hold across stalls.
   always_comb begin
      state_nxt = state;
      valid_c   = 1'b0;
      sop_c     = 1'b0;
      eop_c     = 1'b0;
      data_c    = '0;
      case (state)
         IDLE: begin
            if (enable) state_nxt = CTRL_HDR;
         end
         CTRL_HDR: begin
            valid_c     = 1'b1;
            sop_c       = 1'b1;
            data_c[3:0] = PKT_CONTROL;
            if (dout.dout_ready) state_nxt = CTRL_BODY;
         end
         CTRL_BODY: begin
            valid_c = 1'b1;
            eop_c   = (body_k == LAST_BODY);
            data_c  = body_data;
            if (dout.dout_ready && eop_c) state_nxt = VID_HDR;
         end
         VID_HDR: begin
            valid_c     = 1'b1;
            sop_c       = 1'b1;
            data_c[3:0] = PKT_VIDEO;
            if (dout.dout_ready) state_nxt = VID_DATA;
         end
         VID_DATA: begin
            valid_c = 1'b1;
            eop_c   = px_last;
            data_c  = {PLANES{pix_val}};
            if (dout.dout_ready && px_last) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign dout.dout_valid = valid_c;
   assign dout.dout_sop   = sop_c;
   assign dout.dout_eop   = eop_c;
   assign dout.dout_data  = data_c;
   assign busy            = (state != IDLE);
   assign dbg_state       = state;

endmodule

// File: tb/tb_vid_tpg_packet_source.sv
// Scoreboard bench for vid_tpg_packet_source: a PLANES=3 instance for the main
// directed frames and a PLANES=1 instance for the single-symbol body layout.
module tb_vid_tpg_packet_source;
   import vid_tpg_packet_source_pkg::*;

   localparam int DW = 24;
   localparam int EW = DW + 3;  // {last_pixel, sop, eop, data}

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        enable1 = 1'b0;
   logic [15:0] cfg_width = '0;
   logic [15:0] cfg_height = '0;
   logic [3:0]  cfg_interlace = '0;
   logic [1:0]  cfg_pattern = '0;
   logic        busy, frame_done, busy1, frame_done1;
   tpg_state_t  dbg_state, dbg_state1;

   vid_tpg_packet_source_if #(.BPS(8), .PLANES(3)) dout ();
   vid_tpg_packet_source_if #(.BPS(8), .PLANES(1)) dout1 ();

   vid_tpg_packet_source #(.BPS(8), .PLANES(3)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_interlace(cfg_interlace), .cfg_pattern(cfg_pattern),
      .dout(dout), .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
   );

   vid_tpg_packet_source #(.BPS(8), .PLANES(1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable1),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_interlace(cfg_interlace), .cfg_pattern(cfg_pattern),
      .dout(dout1), .busy(busy1), .frame_done(frame_done1), .dbg_state(dbg_state1)
   );

   assign dout1.dout_ready = 1'b1;

   always #5 clk = ~clk;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp_q1[$];
   int            total = 0;
   int            bad = 0;
   int            xfer_count = 0;
   int            done_count = 0;
   int            xfer1 = 0;
   int            done1_count = 0;
   int            ready_mode = 0;
   int            base;
   int            gap_cnt = 0;
   bit            fd_pending = 0;
   bit            hold_armed = 0;
   bit            gap_arm = 0;
   bit            gap_on = 0;
   logic [DW+2:0] hold_val;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input bit second, input logic [EW-1:0] e);
      if (second) exp_q1.push_back(e);
      else exp_q.push_back(e);
   endtask

   // Reference frame for any plane count (8-bit symbols, zero-extended to 24 bits).
   task automatic push_frame(input int planes, input logic [15:0] w, input logic [15:0] h,
                             input logic [3:0] il, input logic [1:0] pat, input bit second);
      logic [3:0]    nib [9];
      logic [DW-1:0] d;
      logic [7:0]    v;
      int            nb, we, he, n;
      bit            last;
      nib = '{w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], il};
      nb  = (9 + planes - 1) / planes;
      push(second, {3'b010, 24'h00000F});
      for (int k = 0; k < nb; k++) begin
         d = '0;
         for (int s = 0; s < planes; s++) begin
            n = k * planes + s;
            if (n < 9) d[s*8 +: 8] = {4'h0, nib[n]};
         end
         push(second, {1'b0, 1'b0, (k == nb - 1), d});
      end
      push(second, {3'b010, 24'h000000});
      we = (w == 16'd0) ? 1 : int'(w);
      he = (h == 16'd0) ? 1 : int'(h);
      for (int y = 0; y < he; y++) begin
         for (int x = 0; x < we; x++) begin
            case (pat)
               2'd0:    v = 8'hFF;
               2'd1:    v = x[7:0];
               2'd2:    v = y[7:0];
               default: v = (((x ^ y) & 8) != 0) ? 8'hFF : 8'h00;
            endcase
            d = '0;
            for (int s = 0; s < planes; s++) d[s*8 +: 8] = v;
            last = (x == we - 1) && (y == he - 1);
            push(second, {last, 1'b0, last, d});
         end
      end
   endtask

   // Hand-written beats for W=4, H=2, pattern 1, interlace 0, three planes.
   task automatic push_table_4x2();
      push(0, {3'b010, 24'h00000F});
      push(0, {3'b000, 24'h000000});
      push(0, {3'b000, 24'h000004});
      push(0, {3'b001, 24'h000200});
      push(0, {3'b010, 24'h000000});
      push(0, {3'b000, 24'h000000});
      push(0, {3'b000, 24'h010101});
      push(0, {3'b000, 24'h020202});
      push(0, {3'b000, 24'h030303});
      push(0, {3'b000, 24'h000000});
      push(0, {3'b000, 24'h010101});
      push(0, {3'b000, 24'h020202});
      push(0, {3'b101, 24'h030303});
   endtask

   task automatic start_frame(input logic [15:0] w, input logic [15:0] h,
                              input logic [3:0] il, input logic [1:0] pat);
      @(posedge clk); #1;
      cfg_width = w; cfg_height = h; cfg_interlace = il; cfg_pattern = pat;
      enable = 1'b1;
      check("valid_idle", dout.dout_valid, 0);
      @(posedge clk); #1;
      enable = 1'b0;
      check("valid_rise", dout.dout_valid, 1);
      check("busy_run", busy, 1);
      // These must not affect the frame already latched.
      cfg_width = 16'h0FFF; cfg_height = 16'h00FF; cfg_interlace = 4'hC; cfg_pattern = ~pat;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int n = 0;
      while (done_count < target && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      check({name, "_done"}, done_count >= target, 1);
   endtask

   initial begin : ready_drv
      dout.dout_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       dout.dout_ready = 1'b1;
            1:       dout.dout_ready = ~dout.dout_ready;
            default: dout.dout_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin : mon
      logic [EW-1:0] e;
      if (rst) begin
         fd_pending = 0;
         hold_armed = 0;
         gap_on     = 0;
      end else begin
         check("frame_done", frame_done, fd_pending);
         if (frame_done) done_count++;
         fd_pending = 0;
         if (hold_armed)
            check("stall_hold", {dout.dout_valid, dout.dout_sop, dout.dout_eop, dout.dout_data}, hold_val);
         hold_armed = 0;
         if (!gap_arm) gap_on = 0;
         if (gap_on && !dout.dout_valid) gap_cnt++;
         if (dout.dout_valid && dout.dout_ready) begin
            xfer_count++;
            if (gap_on && dout.dout_sop) begin
               check("idle_gap", gap_cnt, 1);
               gap_on = 0;
            end
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL beat: unexpected beat %0h, queue empty", dout.dout_data);
            end else begin
               e = exp_q.pop_front();
               check("beat", {dout.dout_sop, dout.dout_eop, dout.dout_data}, e[EW-2:0]);
               if (e[EW-1]) begin
                  fd_pending = 1;
                  if (gap_arm) begin gap_on = 1; gap_cnt = 0; end
               end
            end
         end else if (dout.dout_valid) begin
            hold_val   = {dout.dout_valid, dout.dout_sop, dout.dout_eop, dout.dout_data};
            hold_armed = 1;
         end
      end
   end

   always @(negedge clk) begin : mon1
      logic [EW-1:0] e1;
      if (!rst) begin
         if (frame_done1) done1_count++;
         if (dout1.dout_valid && dout1.dout_ready) begin
            xfer1++;
            if (exp_q1.size() == 0) begin
               total++; bad++;
               $display("FAIL beat1: unexpected beat %0h, queue empty", dout1.dout_data);
            end else begin
               e1 = exp_q1.pop_front();
               check("beat1", {dout1.dout_sop, dout1.dout_eop, 16'h0000, dout1.dout_data}, e1[EW-2:0]);
            end
         end
      end
   end

   initial begin : main
      int n;
      #3;
      check("rst_valid", dout.dout_valid, 0);
      check("rst_sop", dout.dout_sop, 0);
      check("rst_eop", dout.dout_eop, 0);
      check("rst_data", dout.dout_data, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Nominal 4x2 ramp frame, sink always ready.
      push_table_4x2();
      start_frame(16'd4, 16'd2, 4'h0, 2'd1);
      wait_done(1, 200, "frame_4x2");
      check("busy_after", busy, 0);

      // Same frame with ready toggling every cycle.
      ready_mode = 1;
      push_table_4x2();
      start_frame(16'd4, 16'd2, 4'h0, 2'd1);
      wait_done(2, 300, "frame_toggle");
      ready_mode = 0;

      // Zero size clamps to a single pixel but encodes 0 in the control body.
      push_frame(3, 16'd0, 16'd0, 4'h3, 2'd0, 0);
      start_frame(16'd0, 16'd0, 4'h3, 2'd0);
      wait_done(3, 200, "frame_zero");

      // Checkerboard and line-ramp patterns under random backpressure.
      ready_mode = 2;
      push_frame(3, 16'd20, 16'd2, 4'hA, 2'd3, 0);
      start_frame(16'd20, 16'd2, 4'hA, 2'd3);
      wait_done(4, 1000, "frame_checker");
      push_frame(3, 16'd3, 16'd3, 4'h5, 2'd2, 0);
      start_frame(16'd3, 16'd3, 4'h5, 2'd2);
      wait_done(5, 500, "frame_yramp");
      ready_mode = 0;

      // Back-to-back frames with enable held high: one idle cycle between them.
      gap_arm = 1;
      push_frame(3, 16'd2, 16'd2, 4'h0, 2'd1, 0);
      push_frame(3, 16'd2, 16'd2, 4'h0, 2'd1, 0);
      @(posedge clk); #1;
      cfg_width = 16'd2; cfg_height = 16'd2; cfg_interlace = 4'h0; cfg_pattern = 2'd1;
      enable = 1'b1;
      wait_done(6, 200, "frame_b2b_first");
      @(posedge clk); #1;
      enable = 1'b0;
      wait_done(7, 200, "frame_b2b_second");
      gap_arm = 0;

      // Reset while pixel 3 is on the bus abandons the frame.
      push_frame(3, 16'd4, 16'd2, 4'h0, 2'd1, 0);
      base = xfer_count;
      start_frame(16'd4, 16'd2, 4'h0, 2'd1);
      n = 0;
      while (xfer_count < base + 9 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      check("reach_pixel3", xfer_count, base + 9);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_valid", dout.dout_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_sop", dout.dout_sop, 0);
      check("midrst_data", dout.dout_data, 0);
      check("midrst_state", dbg_state, IDLE);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      push_frame(3, 16'd4, 16'd2, 4'h0, 2'd1, 0);
      start_frame(16'd4, 16'd2, 4'h0, 2'd1);
      wait_done(8, 200, "frame_after_rst");

      // Single-plane instance, 1x1 frame: 9 body beats, 12 beats total.
      push_frame(1, 16'd1, 16'd1, 4'h6, 2'd0, 1);
      @(posedge clk); #1;
      cfg_width = 16'd1; cfg_height = 16'd1; cfg_interlace = 4'h6; cfg_pattern = 2'd0;
      enable1 = 1'b1;
      @(posedge clk); #1;
      enable1 = 1'b0;
      n = 0;
      while (done1_count < 1 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      check("p1_done", done1_count, 1);
      check("p1_beats", xfer1, 12);

      check("exp_q_empty", exp_q.size(), 0);
      check("exp_q1_empty", exp_q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
